// File: rtl/vid_timing_gen_if.sv
// rtl/vid_timing_gen_if.sv - video output bus: pixel data, syncs, data-enable and position
interface vid_timing_gen_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] o_vid_data;
  logic                  o_vid_hsync;
  logic                  o_vid_vsync;
  logic                  o_vid_VDE;
  logic [11:0]           o_hcount;
  logic [10:0]           o_vcount;
  logic                  o_frame_start;

  modport master (
    output o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE,
    output o_hcount, o_vcount, o_frame_start
  );

  modport slave (
    input o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE,
    input o_hcount, o_vcount, o_frame_start
  );
endinterface

// File: rtl/vid_timing_gen.sv
// rtl/vid_timing_gen.sv - raster timing generator with bars/ramp/checker/grey/white test patterns
module vid_timing_gen #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_enable,
  input  logic [3:0]           sw,
  vid_timing_gen_if.master     vid
);

  // Last count value of each region; the FSMs step when the counter sits on one of these.
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] H_FP_END   = 12'(H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE - 1);
  localparam logic [10:0] V_FP_END   = 11'(V_ACTIVE + V_FP - 1);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [14:0] H_ACT_DIV  = 15'(H_ACTIVE);

  typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_e;
  typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_e;

  h_state_e              h_state_q, h_state_d;
  v_state_e              v_state_q, v_state_d;
  logic [11:0]           hcount_q, hcount_d;
  logic [10:0]           vcount_q, vcount_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic [3:0]            pattern_q, pattern_d;
  logic [DATA_WIDTH-1:0] vid_data_q, vid_data_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  vde_q, vde_d;
  logic [11:0]           hcount_out_q, hcount_out_d;
  logic [10:0]           vcount_out_q, vcount_out_d;
  logic                  frame_start_q, frame_start_d;

  logic                  h_wrap;
  logic                  v_wrap;
  logic                  at_origin;
  logic [3:0]            pattern_cur;
  logic [14:0]           bar_num;
  logic [2:0]            bar_idx;
  logic [23:0]           pix;

  assign h_wrap    = (hcount_q == H_LAST);
  assign v_wrap    = (vcount_q == V_LAST);
  assign at_origin = (hcount_q == 12'd0) && (vcount_q == 11'd0);
  // The first pixel of a frame already uses the newly sampled pattern.
  assign pattern_cur = at_origin ? sw : pattern_q;
  assign bar_num     = {hcount_q, 3'b000};
  assign bar_idx     = 3'(bar_num / H_ACT_DIV);

  always_comb begin
    pix = 24'hFFFFFF;
    case (pattern_cur)
      4'b0000: begin
        case (bar_idx)
          3'd0:    pix = 24'hFFFFFF;
          3'd1:    pix = 24'hFF00FF;
          3'd2:    pix = 24'h00FFFF;
          3'd3:    pix = 24'h0000FF;
          3'd4:    pix = 24'hFFFF00;
          3'd5:    pix = 24'hFF0000;
          3'd6:    pix = 24'h00FF00;
          default: pix = 24'h000000;
        endcase
      end
      4'b0001: pix = {3{hcount_q[7:0]}};
      4'b0010: pix = (hcount_q[CHECK_LOG2] ^ vcount_q[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
      4'b0011: pix = {3{frame_cnt_q}};
      default: pix = 24'hFFFFFF;
    endcase
  end

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    h_state_d     = h_state_q;
    v_state_d     = v_state_q;
    frame_cnt_d   = frame_cnt_q;
    pattern_d     = pattern_q;
    vid_data_d    = '0;
    hsync_d       = 1'b0;
    vsync_d       = 1'b0;
    vde_d         = 1'b0;
    hcount_out_d  = 12'd0;
    vcount_out_d  = 11'd0;
    frame_start_d = 1'b0;

    if (!i_enable) begin
      hcount_d  = 12'd0;
      vcount_d  = 11'd0;
      h_state_d = HS_ACT;
      v_state_d = VS_ACT;
    end else begin
      hcount_d = h_wrap ? 12'd0 : hcount_q + 12'd1;
      if (h_wrap) begin
        vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
        if (v_wrap) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end

      if (hcount_q == H_ACT_END)       h_state_d = HS_FP;
      else if (hcount_q == H_FP_END)   h_state_d = HS_SYNC;
      else if (hcount_q == H_SYNC_END) h_state_d = HS_BP;
      else if (h_wrap)                 h_state_d = HS_ACT;

      // Vertical state only moves at the end of a line.
      if (h_wrap) begin
        if (vcount_q == V_ACT_END)       v_state_d = VS_FP;
        else if (vcount_q == V_FP_END)   v_state_d = VS_SYNC;
        else if (vcount_q == V_SYNC_END) v_state_d = VS_BP;
        else if (v_wrap)                 v_state_d = VS_ACT;
      end

      pattern_d     = pattern_cur;
      vde_d         = (h_state_q == HS_ACT) && (v_state_q == VS_ACT);
      hsync_d       = (h_state_q == HS_SYNC);
      vsync_d       = (v_state_q == VS_SYNC);
      vid_data_d    = vde_d ? DATA_WIDTH'(pix) : '0;
      hcount_out_d  = hcount_q;
      vcount_out_d  = vcount_q;
      frame_start_d = at_origin;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hcount_q      <= 12'd0;
      vcount_q      <= 11'd0;
      h_state_q     <= HS_ACT;
      v_state_q     <= VS_ACT;
      frame_cnt_q   <= 8'd0;
      pattern_q     <= 4'b0000;
      vid_data_q    <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vde_q         <= 1'b0;
      hcount_out_q  <= 12'd0;
      vcount_out_q  <= 11'd0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      frame_cnt_q   <= frame_cnt_d;
      pattern_q     <= pattern_d;
      vid_data_q    <= vid_data_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      vde_q         <= vde_d;
      hcount_out_q  <= hcount_out_d;
      vcount_out_q  <= vcount_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.o_vid_data    = vid_data_q;
  assign vid.o_vid_hsync   = hsync_q;
  assign vid.o_vid_vsync   = vsync_q;
  assign vid.o_vid_VDE     = vde_q;
  assign vid.o_hcount      = hcount_out_q;
  assign vid.o_vcount      = vcount_out_q;
  assign vid.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb/tb_vid_timing_gen.sv - scoreboard bench for vid_timing_gen on a 14x7 raster
module tb_vid_timing_gen;

  logic       clk;
  logic       n_rst;
  logic       i_enable;
  logic [3:0] sw;

  int checks = 0;
  int errors = 0;

  vid_timing_gen_if #(.DATA_WIDTH(24)) vid ();

  vid_timing_gen #(
    .DATA_WIDTH(24),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CHECK_LOG2(1)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .i_enable(i_enable),
    .sw(sw),
    .vid(vid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] data;
    logic        hs;
    logic        vs;
    logic        vde;
    logic        fs;
    logic [11:0] hc;
    logic [10:0] vc;
  } exp_t;

  exp_t sb[$];

  int         mh = 0;
  int         mv = 0;
  logic [7:0] mframe = 8'd0;
  logic [3:0] mpat = 4'd0;

  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFF00FF;
      2:       return 24'h00FFFF;
      3:       return 24'h0000FF;
      4:       return 24'hFFFF00;
      5:       return 24'hFF0000;
      6:       return 24'h00FF00;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model(input logic en, input logic [3:0] s);
    exp_t e;
    logic [7:0] r;
    e = '0;
    if (!en) begin
      mh = 0;
      mv = 0;
    end else begin
      if (mh == 0 && mv == 0) mpat = s;
      e.hc  = 12'(mh);
      e.vc  = 11'(mv);
      e.fs  = (mh == 0 && mv == 0);
      e.hs  = (mh >= 10 && mh <= 11);
      e.vs  = (mv == 5);
      e.vde = (mh < 8 && mv < 4);
      r     = 8'(mh);
      if (e.vde) begin
        case (mpat)
          4'd0:    e.data = bar_colour(mh);
          4'd1:    e.data = {r, r, r};
          4'd2:    e.data = ((((mh >> 1) ^ (mv >> 1)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
          4'd3:    e.data = {mframe, mframe, mframe};
          default: e.data = 24'hFFFFFF;
        endcase
      end
      mh = mh + 1;
      if (mh == 14) begin
        mh = 0;
        mv = mv + 1;
        if (mv == 7) begin
          mv = 0;
          mframe = mframe + 8'd1;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    logic [50:0] obs;
    logic [50:0] expv;
    e    = sb.pop_front();
    obs  = {vid.o_vid_data, vid.o_vid_hsync, vid.o_vid_vsync, vid.o_vid_VDE,
            vid.o_frame_start, vid.o_hcount, vid.o_vcount};
    expv = e;
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL pixel h=%0d v=%0d observed=%h expected=%h", e.hc, e.vc, obs, expv);
    end
  endtask

  task automatic step(input logic en, input logic [3:0] s);
    i_enable = en;
    sw       = s;
    model(en, s);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data"}, 32'(vid.o_vid_data), 32'h0);
    chk({tag, "_hsync"}, 32'(vid.o_vid_hsync), 32'h0);
    chk({tag, "_vsync"}, 32'(vid.o_vid_vsync), 32'h0);
    chk({tag, "_vde"}, 32'(vid.o_vid_VDE), 32'h0);
    chk({tag, "_fs"}, 32'(vid.o_frame_start), 32'h0);
    chk({tag, "_hc"}, 32'(vid.o_hcount), 32'h0);
    chk({tag, "_vc"}, 32'(vid.o_vcount), 32'h0);
  endtask

  initial begin
    n_rst    = 1'b0;
    i_enable = 1'b0;
    sw       = 4'd0;
    #2;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Bars, then sw switched to ramp at line 1 hcount 3: ramp only next frame.
    step(1'b1, 4'd0);
    chk("bars_first_fs", 32'(vid.o_frame_start), 32'h1);
    chk("bars_first_data", 32'(vid.o_vid_data), 32'hFFFFFF);
    repeat (9) step(1'b1, 4'd0);
    step(1'b1, 4'd0);
    chk("hsync_h10", 32'(vid.o_vid_hsync), 32'h1);
    repeat (6) step(1'b1, 4'd0);
    repeat (81) step(1'b1, 4'd1);
    repeat (7) step(1'b1, 4'd1);
    step(1'b1, 4'd1);
    chk("ramp_h7_data", 32'(vid.o_vid_data), 32'h070707);
    repeat (90) step(1'b1, 4'd1);

    // Checkerboard for two frames.
    repeat (28) step(1'b1, 4'd2);
    step(1'b1, 4'd2);
    chk("checker_l2_h0", 32'(vid.o_vid_data), 32'h000000);
    repeat (167) step(1'b1, 4'd2);

    // Enable dropped for 20 cycles mid-frame; four frames completed so far.
    repeat (30) step(1'b1, 4'd3);
    repeat (20) step(1'b0, 4'd3);
    step(1'b1, 4'd3);
    chk("restart_fs", 32'(vid.o_frame_start), 32'h1);
    chk("restart_grey", 32'(vid.o_vid_data), 32'h040404);
    repeat (97) step(1'b1, 4'd3);

    // Asynchronous reset at line 2 hcount 5, between clock edges.
    repeat (33) step(1'b1, 4'd0);
    chk("pre_rst_data", 32'(vid.o_vid_data), 32'hFFFF00);
    #3;
    n_rst = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    mh     = 0;
    mv     = 0;
    mframe = 8'd0;
    mpat   = 4'd0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Grey frame counter after reset: 0, 1, then wraps to 0 at frame 256.
    step(1'b1, 4'd3);
    chk("post_rst_fs", 32'(vid.o_frame_start), 32'h1);
    chk("post_rst_hc", 32'(vid.o_hcount), 32'h0);
    chk("post_rst_vc", 32'(vid.o_vcount), 32'h0);
    chk("grey_f0", 32'(vid.o_vid_data), 32'h000000);
    repeat (97) step(1'b1, 4'd3);
    step(1'b1, 4'd3);
    chk("grey_f1_fs", 32'(vid.o_frame_start), 32'h1);
    chk("grey_f1", 32'(vid.o_vid_data), 32'h010101);
    repeat (24989) step(1'b1, 4'd3);
    step(1'b1, 4'd3);
    chk("grey_f256_fs", 32'(vid.o_frame_start), 32'h1);
    chk("grey_f256", 32'(vid.o_vid_data), 32'h000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vid_timing_gen.md
VID_TIMING_GEN -- requirements
Module: vid_timing_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, pixel width packed {red[23:16], blue[15:8], green[7:0]}.
REQ-002 SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 1920/88/44/148, horizontal timing in pixels (H_TOTAL = sum = 2200).
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 1080/4/5/36, vertical timing in lines (V_TOTAL = sum = 1125).
REQ-004 SHALL have parameter CHECK_LOG2, default 5, log2 of checkerboard cell size in pixels.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port n_rst, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port i_enable, input, 1, run timing when high.
REQ-008 SHALL have port sw, input, 4, pattern select.
REQ-009 SHALL have port o_vid_data, output, DATA_WIDTH, pixel data.
REQ-010 SHALL have ports o_vid_hsync, o_vid_vsync, o_vid_VDE, output, 1 each, active-high sync and data-enable.
REQ-011 SHALL have ports o_hcount (12) and o_vcount (11), output, position of the pixel currently on o_vid_*.
REQ-012 SHALL have port o_frame_start, output, 1, one-cycle pulse on first pixel of each frame.

Function
REQ-013 SHALL keep internal hcount 0..H_TOTAL-1, incrementing each enabled cycle, wrapping to 0; vcount increments on hcount wrap, wraps to 0 after V_TOTAL-1.
REQ-014 SHALL implement horizontal FSM H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT, transitions at hcount = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, H_TOTAL (wrap).
REQ-015 SHALL implement vertical FSM V_ACT -> V_FP -> V_SYNC -> V_BP -> V_ACT with identical boundaries in lines, state changing only on hcount wrap.
REQ-016 SHALL register all outputs; o_vid_*, o_hcount, o_vcount, o_frame_start reflect counter state one cycle earlier, mutually aligned.
REQ-017 SHALL assert hsync exactly in H_SYNC, vsync exactly in V_SYNC (whole lines), VDE only when H_ACT and V_ACT.
REQ-018 SHALL drive o_vid_data = 0 whenever VDE is 0.
REQ-019 SHALL latch sw into the active pattern only when hcount=0 and vcount=0; mid-frame sw changes take effect next frame.
REQ-020 SHALL produce, sw=0000: 8 colour bars, index = (hcount*8)/H_ACTIVE: FFFFFF, FF00FF, 00FFFF, 0000FF, FFFF00, FF0000, 00FF00, 000000.
REQ-021 SHALL produce, sw=0001: horizontal ramp, all three channels = hcount[7:0].
REQ-022 SHALL produce, sw=0010: checkerboard, FFFFFF when hcount[CHECK_LOG2] XOR vcount[CHECK_LOG2] = 0, else 000000.
REQ-023 SHALL produce, sw=0011: solid grey, all channels = 8-bit frame counter.
REQ-024 SHALL produce, any other sw: solid FFFFFF.
REQ-025 SHALL keep 8-bit frame counter incrementing on vcount wrap, 255 -> 0 wrap.
REQ-026 SHALL pulse o_frame_start for one cycle with the output pixel at hcount=0, vcount=0.
REQ-027 SHALL, while i_enable=0, hold counters at 0, FSMs in H_ACT/V_ACT, and drive all o_vid_* and o_frame_start to 0; frame counter holds.
REQ-028 SHALL, on i_enable rising, emit pixel (0,0) with o_frame_start=1 on the cycle after the first enabled cycle.
REQ-029 SHALL, on i_enable falling mid-frame, abandon the frame; outputs 0 from the next cycle.

Reset
REQ-030 SHALL, on n_rst=0, immediately clear counters, frame counter, latched pattern (0000), FSMs (H_ACT/V_ACT) and all outputs to 0, independent of clk.
REQ-031 SHALL, after n_rst release mid-frame, restart at (0,0) like REQ-028 if i_enable=1.

Verification
REQ-032 SHALL verify with H=8/2/2/2, V=4/1/1/1, CHECK_LOG2=1, sw=0000, enable held: line = 14 cycles, VDE high 8 cycles with data FFFFFF,FF00FF,00FFFF,0000FF,FFFF00,FF0000,00FF00,000000, hsync high at hcount 10-11, frame = 98 cycles, vsync high for all of line 5.
REQ-033 SHALL verify sw=0010 (same params): line 0 data FFFFFF,FFFFFF,000000,000000,... ; line 2 inverted.
REQ-034 SHALL verify sw=0011: frame 0 data 000000, frame 1 010101, after 256 frames 000000 again.
REQ-035 SHALL verify sw 0000 -> 0001 at hcount=3 line 1: rest of frame remains bars; next frame line 0 data 000000..070707.
REQ-036 SHALL verify n_rst low at line 2 hcount 5 between clock edges: outputs 0 before next edge; after release, o_frame_start=1 with o_hcount=0, o_vcount=0 one cycle after first enabled edge.
REQ-037 SHALL verify i_enable low for 20 cycles mid-frame: hsync/vsync/VDE/data = 0 throughout, frame counter unchanged, restart at (0,0).
